// File: rtl/pe_frame_sched_if.sv
// ============================================================================
//  Module   : pe_frame_sched_if
//  Purpose  : Upstream word stream plus pe_control write/readout signals.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pe_frame_sched_if #(
  parameter int DATA_W = 32
);
  logic              s_vld;
  logic [DATA_W-1:0] s_data;
  logic              s_rdy;
  logic              wr_sop;
  logic              wr_eop;
  logic              wr_vld;
  logic [DATA_W-1:0] wr_data;
  logic              rd_sop;

  // Environment side: produces words, consumes the frame/readout signals
  modport master (
    output s_vld, s_data,
    input  s_rdy, wr_sop, wr_eop, wr_vld, wr_data, rd_sop
  );

  // Sequencer side
  modport slave (
    input  s_vld, s_data,
    output s_rdy, wr_sop, wr_eop, wr_vld, wr_data, rd_sop
  );
endinterface

`default_nettype wire

// File: rtl/pe_frame_sched.sv
// ============================================================================
//  Module   : pe_frame_sched
//  Purpose  : Forms fixed-length write frames from a word stream, then fires
//             a readout start once the last RAM write has landed.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_frame_sched #(
  parameter int FRAME_BEATS = 10,
  parameter int WR2RD_GAP   = 2,
  parameter int RD_CYCLES   = 18,
  parameter int CNT_W       = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             run,
  input  wire logic             abort,
  pe_frame_sched_if.slave       bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int c_beat_w = $clog2(FRAME_BEATS);
  localparam int c_gap_w  = (WR2RD_GAP > 1) ? $clog2(WR2RD_GAP) : 1;
  localparam int c_rd_w   = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;

  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(FRAME_BEATS - 1);
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(WR2RD_GAP - 1);
  localparam logic [c_rd_w-1:0]   c_rd_last   = c_rd_w'(RD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_READ = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_beat_w-1:0] r_beat_cnt;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_rd_w-1:0]   r_rd_cnt;
  logic                r_wr_sop;
  logic                r_wr_eop;
  logic                r_wr_vld;
  logic [31:0]         r_wr_data;
  logic                r_rd_sop;
  logic                r_busy;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic w_s_rdy;
  logic w_hs;

  assign w_s_rdy = (r_state == ST_LOAD);
  assign w_hs    = bus.s_vld & w_s_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_rd_cnt     <= '0;
      r_wr_sop     <= 1'b0;
      r_wr_eop     <= 1'b0;
      r_wr_vld     <= 1'b0;
      r_wr_data    <= '0;
      r_rd_sop     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_wr_sop     <= 1'b0;
      r_wr_eop     <= 1'b0;
      r_wr_vld     <= 1'b0;
      r_rd_sop     <= 1'b0;
      r_frame_done <= 1'b0;

      // A word accepted in the abort cycle is dropped with the partial frame
      if (abort) begin
        r_state    <= ST_IDLE;
        r_beat_cnt <= '0;
        r_gap_cnt  <= '0;
        r_rd_cnt   <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run) begin
              r_state <= ST_LOAD;
              r_busy  <= 1'b1;
            end
          end

          ST_LOAD: begin
            if (w_hs) begin
              r_wr_vld  <= 1'b1;
              r_wr_data <= bus.s_data;
              r_wr_sop  <= (r_beat_cnt == '0);
              r_wr_eop  <= (r_beat_cnt == c_beat_last);
              if (r_beat_cnt == c_beat_last) begin
                r_beat_cnt <= '0;
                r_state    <= ST_GAP;
              end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
              end
            end
          end

          ST_GAP: begin
            if (r_gap_cnt == c_gap_last) begin
              r_gap_cnt <= '0;
              r_state   <= ST_READ;
              r_rd_sop  <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end

          ST_READ: begin
            if (r_rd_cnt == c_rd_last) begin
              r_rd_cnt     <= '0;
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 1'b1;
              if (run) begin
                r_state <= ST_LOAD;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.s_rdy   = w_s_rdy;
  assign bus.wr_sop  = r_wr_sop;
  assign bus.wr_eop  = r_wr_eop;
  assign bus.wr_vld  = r_wr_vld;
  assign bus.wr_data = r_wr_data;
  assign bus.rd_sop  = r_rd_sop;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pe_frame_sched.sv
// ============================================================================
//  Module   : tb_pe_frame_sched
//  Purpose  : Scoreboard bench for pe_frame_sched (default and CNT_W=2 copies).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_frame_sched;

  localparam int FRAME_BEATS = 10;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        run    = 1'b0;
  logic        abort  = 1'b0;
  logic        s_vld  = 1'b0;
  logic [31:0] s_data = '0;

  logic       busy, frame_done, busy2, frame_done2;
  logic [7:0] frame_cnt;
  logic [1:0] frame_cnt2;

  pe_frame_sched_if bus  ();
  pe_frame_sched_if bus2 ();

  assign bus.s_vld   = s_vld;
  assign bus.s_data  = s_data;
  assign bus2.s_vld  = s_vld;
  assign bus2.s_data = s_data;

  pe_frame_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  pe_frame_sched #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .abort      (abort),
    .bus        (bus2),
    .busy       (busy2),
    .frame_done (frame_done2),
    .frame_cnt  (frame_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc, idx, exp_cnt;
  int n_vld, n_sop, n_eop, n_rdsop, n_done;
  bit in_rd, rec;
  int t_rdy0, t_rdy1, rdy_n, t_vld0, t_vld1, vld_n;
  int t_sop, t_eop, t_rds, rds_n, t_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: check what the last rising edge produced, then drive
  task automatic step(input logic vld, input logic ab);
    beat_t e;
    logic  hs;
    if (bus.wr_vld) begin
      n_vld++;
      if (bus.wr_sop) n_sop++;
      if (bus.wr_eop) n_eop++;
      if (sb.size() == 0) begin
        chk("wr_vld_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_data", bus.wr_data, e.data);
        chk("wr_sop", bus.wr_sop, e.sop);
        chk("wr_eop", bus.wr_eop, e.eop);
      end
    end else begin
      chk("sop_eop_without_vld", {bus.wr_sop, bus.wr_eop}, 32'd0);
    end
    if (bus.rd_sop) n_rdsop++;
    if (frame_done) begin
      n_done++;
      exp_cnt++;
      chk("frame_cnt", frame_cnt, exp_cnt % 256);
      chk("frame_cnt_w2", frame_cnt2, exp_cnt % 4);
      in_rd = 1'b0;
    end
    if (bus.wr_eop) in_rd = 1'b1;
    if (in_rd) chk("rdy_in_gap_read", bus.s_rdy, 32'd0);

    if (rec && cyc >= 0 && cyc <= 30) begin
      if (bus.s_rdy && cyc < 30) begin
        rdy_n++;
        if (t_rdy0 < 0) t_rdy0 = cyc;
        t_rdy1 = cyc;
      end
      if (bus.wr_vld && cyc < 30) begin
        vld_n++;
        if (t_vld0 < 0) t_vld0 = cyc;
        t_vld1 = cyc;
      end
      if (bus.wr_sop && t_sop < 0) t_sop = cyc;
      if (bus.wr_eop && t_eop < 0) t_eop = cyc;
      if (bus.rd_sop) begin
        rds_n++;
        t_rds = cyc;
      end
      if (frame_done && t_done < 0) t_done = cyc;
    end

    s_vld  = vld;
    s_data = $urandom;
    abort  = ab;
    #1;
    hs = s_vld && bus.s_rdy;
    if (ab) begin
      idx = 0;
    end else if (hs) begin
      e.data = s_data;
      e.sop  = (idx == 0);
      e.eop  = (idx == FRAME_BEATS - 1);
      sb.push_back(e);
      idx = (idx == FRAME_BEATS - 1) ? 0 : idx + 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Run until `target` frames are done; run drops once the final frame is loading
  task automatic wait_frames(input int target, input bit toggle);
    logic v;
    int   guard;
    v     = 1'b1;
    guard = 0;
    while (n_done < target && guard < 400) begin
      if (n_done >= target - 1 && busy) run = 1'b0;
      step(v, 1'b0);
      if (toggle) v = ~v;
      guard++;
    end
    chk("frames_done_in_budget", n_done, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_rdy"}, bus.s_rdy, 0);
    chk({tag, "_wr_vld"}, bus.wr_vld, 0);
    chk({tag, "_wr_sop"}, bus.wr_sop, 0);
    chk({tag, "_wr_eop"}, bus.wr_eop, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_rd_sop"}, bus.rd_sop, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_frame_cnt_w2"}, frame_cnt2, 0);
  endtask

  initial begin
    int b_vld, b_sop, b_eop, b_rds, b_done, b_cnt, guard;
    idx = 0; exp_cnt = 0; cyc = 0;
    n_vld = 0; n_sop = 0; n_eop = 0; n_rdsop = 0; n_done = 0;
    in_rd = 1'b0; rec = 1'b0;
    t_rdy0 = -1; t_rdy1 = -1; rdy_n = 0; t_vld0 = -1; t_vld1 = -1; vld_n = 0;
    t_sop = -1; t_eop = -1; t_rds = -1; rds_n = 0; t_done = -1;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Continuous stream, three back-to-back frames, first frame timed
    run = 1'b1;
    cyc = -1;
    rec = 1'b1;
    wait_frames(3, 1'b0);
    rec = 1'b0;
    chk("t1_rdy_first", t_rdy0, 0);
    chk("t1_rdy_last", t_rdy1, 9);
    chk("t1_rdy_count", rdy_n, 10);
    chk("t1_vld_first", t_vld0, 1);
    chk("t1_vld_last", t_vld1, 10);
    chk("t1_vld_count", vld_n, 10);
    chk("t1_wr_sop_cycle", t_sop, 1);
    chk("t1_wr_eop_cycle", t_eop, 10);
    chk("t1_rd_sop_cycle", t_rds, 12);
    chk("t1_rd_sop_count", rds_n, 1);
    chk("t1_done_cycle", t_done, 30);
    chk("t3_rd_sop_total", n_rdsop, 3);
    chk("t3_frame_cnt", frame_cnt, 3);
    step(1'b0, 1'b0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_rdy", bus.s_rdy, 0);

    // Toggling valid: still exactly one frame of ten beats
    b_vld = n_vld; b_sop = n_sop; b_eop = n_eop;
    run = 1'b1;
    wait_frames(n_done + 1, 1'b1);
    chk("t2_beats", n_vld - b_vld, 10);
    chk("t2_sop", n_sop - b_sop, 1);
    chk("t2_eop", n_eop - b_eop, 1);
    chk("t2_sb_empty", sb.size(), 0);

    // Abort after five beats; the following frame must be complete and fresh
    b_vld = n_vld; b_sop = n_sop; b_eop = n_eop; b_rds = n_rdsop;
    b_done = n_done; b_cnt = int'(frame_cnt);
    run = 1'b1;
    guard = 0;
    while (idx < 5 && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("t4_reached_beat5", idx, 5);
    step(1'b0, 1'b1);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_rdy", bus.s_rdy, 0);
    chk("t4_abort_cnt_held", frame_cnt, b_cnt);
    wait_frames(n_done + 1, 1'b0);
    chk("t4_sop", n_sop - b_sop, 2);
    chk("t4_beats", n_vld - b_vld, 15);
    chk("t4_eop", n_eop - b_eop, 1);
    chk("t4_rd_sop", n_rdsop - b_rds, 1);
    chk("t4_done", n_done - b_done, 1);
    chk("t4_frame_cnt", frame_cnt, (b_cnt + 1) % 256);

    // Reset while reading out
    b_rds = n_rdsop;
    run = 1'b1;
    guard = 0;
    while (n_rdsop == b_rds && guard < 100) begin
      if (busy) run = 1'b0;
      step(1'b1, 1'b0);
      guard++;
    end
    chk("t5_reached_read", n_rdsop, b_rds + 1);
    repeat (3) step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_in_reset");
    sb.delete();
    idx = 0; exp_cnt = 0; in_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t5_after_busy", busy, 0);
    chk("t5_after_rdy", bus.s_rdy, 0);
    chk("t5_after_cnt", frame_cnt, 0);

    // Five frames: 8-bit counter 1..5, 2-bit counter 1,2,3,0,1
    run = 1'b1;
    wait_frames(n_done + 5, 1'b0);
    chk("t6_cnt8", frame_cnt, 5);
    chk("t6_cnt2", frame_cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
